// File: rtl/ram_bank.sv
// ram_bank: parametrised single-port RAM with a registered read port and a clear sweep.
// Optional RAM_WRITE_THROUGH_EN: write-first forwarding of X onto Y during a store.
module ram_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              cl,
  input  logic              rst_n,
  input  logic              st,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] X,
  input  logic              clr,
  output logic [DATA_W-1:0] Y,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] y_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // The sweep owns the write port while clearing; clr beats a coincident store.
  always_comb begin
    we    = 1'b0;
    waddr = ad;
    wdata = X;
    if (state_q == S_CLEAR) begin
      we    = rst_n;
      waddr = ptr_q;
      wdata = '0;
    end else if (st && !clr) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge cl) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          y_q <= '0;
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (clr) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
          end else begin
`ifdef RAM_WRITE_THROUGH_EN
            y_q <= st ? X : mem[ad];
`else
            y_q <= mem[ad];
`endif
          end
        end
        default: begin
          state_q <= S_CLEAR;
          ptr_q   <= '0;
          y_q     <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign Y    = y_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: reference memory model feeds a queue of expected Y values.
module tb_ram_bank;

  logic        cl;
  logic        rst_n;
  logic        st;
  logic [3:0]  ad;
  logic [15:0] X;
  logic        clr;
  logic [15:0] Y;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] mdl [16];
  logic [15:0] exp_q [$];

  ram_bank #(.DATA_W(16), .ADDR_W(4)) dut (
    .cl   (cl),
    .rst_n(rst_n),
    .st   (st),
    .ad   (ad),
    .X    (X),
    .clr  (clr),
    .Y    (Y),
    .busy (busy)
  );

  initial cl = 1'b0;
  always #5 cl = ~cl;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_y(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {16'h0, Y}, {16'h0, e});
    end
  endtask

  task automatic rd(input logic [3:0] a);
    st = 1'b0; clr = 1'b0; ad = a;
    exp_q.push_back(mdl[a]);
    @(posedge cl); #1;
    chk_y($sformatf("rd%0d", a));
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    st = 1'b1; clr = 1'b0; ad = a; X = d;
`ifdef RAM_WRITE_THROUGH_EN
    exp_q.push_back(d);
`else
    exp_q.push_back(mdl[a]);
`endif
    mdl[a] = d;
    @(posedge cl); #1;
    st = 1'b0;
    chk_y($sformatf("wr%0d", a));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
  endtask

  task automatic start_clr(input logic st_v, input logic [3:0] a, input logic [15:0] d);
    clr = 1'b1; st = st_v; ad = a; X = d;
    @(posedge cl); #1;
    clr = 1'b0; st = 1'b0;
    chk("clr_busy", {31'h0, busy}, 32'd1);
    chk("clr_y", {16'h0, Y}, 32'd0);
    clear_model();
  endtask

  // Counts edges until busy falls; optionally hammers stores and re-pulses clr.
  task automatic sweep(input string tag, input int clr_at, input bit hold);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (hold) begin st = 1'b1; ad = 4'd7; X = 16'h7777; end
      clr = (n + 1 == clr_at);
      @(posedge cl); #1;
      n++;
    end
    st = 1'b0; clr = 1'b0;
    chk({tag, "_len"}, n, 32'd16);
    chk({tag, "_y"}, {16'h0, Y}, 32'd0);
    clear_model();
  endtask

  initial begin
    rst_n = 1'b0; st = 1'b0; clr = 1'b0; ad = '0; X = '0;
    clear_model();
    repeat (2) @(posedge cl);
    #1;
    chk("rst_y", {16'h0, Y}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd1);
    rst_n = 1'b1;
    sweep("rst_sweep", 0, 1'b0);
    for (int i = 0; i < 16; i++) rd(4'(i));

    wr(4'd3, 16'hBEEF);
    rd(4'd3);
    rd(4'd4);

    wr(4'd5, 16'h1234);
    wr(4'd5, 16'hABCD);
    rd(4'd5);

    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF);
    rd(4'd0);
    start_clr(1'b1, 4'd0, 16'h5555);
    sweep("clr_sweep", 0, 1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i));

    wr(4'd7, 16'h0F0F);
    start_clr(1'b0, 4'd0, 16'h0);
    sweep("lock_sweep", 8, 1'b1);
    rd(4'd7);
    rd(4'd0);

    start_clr(1'b0, 4'd0, 16'h0);
    repeat (6) @(posedge cl);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", {16'h0, Y}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd1);
    @(posedge cl); #1;
    rst_n = 1'b1;
    sweep("mid_rst_sweep", 0, 1'b0);

    wr(4'd9, 16'hC0DE);
    rd(4'd9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("idle_rst_y", {16'h0, Y}, 32'd0);
    chk("idle_rst_busy", {31'h0, busy}, 32'd1);
    @(posedge cl); #1;
    rst_n = 1'b1;
    sweep("idle_rst_sweep", 0, 1'b0);
    rd(4'd9);
    rd(4'd15);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
